// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF fetches and MEM loads/stores onto one
// req/ack memory port, with data-first fairness-limited arbitration and a hang watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int DFAIR   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  bus_err,
    output logic                  err_src
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] DFAIR_C = 8'(DFAIR);
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;      // 1 = data port owns the transaction
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                abort_q, abort_d;
    logic                err_src_q, err_src_d;
    logic [7:0]          dcnt_q, dcnt_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic                grant_data;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        abort_d    = abort_q;
        err_src_d  = err_src_q;
        dcnt_d     = dcnt_q;
        wcnt_d     = wcnt_q;
        grant_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    // data wins ties until it has taken DFAIR grants in a row past a waiting fetch
                    grant_data = d_req && !(if_req && dcnt_q == DFAIR_C);
                    owner_d    = grant_data;
                    addr_d     = grant_data ? d_addr : if_addr;
                    we_d       = grant_data && d_we;
                    wdata_d    = d_wdata;
                    be_d       = grant_data ? d_be : '1;
                    abort_d    = 1'b0;
                    wcnt_d     = 8'd0;
                    if (grant_data && if_req)
                        dcnt_d = (dcnt_q == 8'hFF) ? dcnt_q : dcnt_q + 8'd1;
                    else
                        dcnt_d = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                wcnt_d = wcnt_q + 8'd1;
                if (mem_ack) begin
                    if (!owner_q)    if_rdata_d = mem_rdata;
                    else if (!we_q)  d_rdata_d  = mem_rdata;
                    state_d = RESP;
                end else if (wcnt_q == WD_LAST) begin
                    abort_d   = 1'b1;
                    err_src_d = owner_q;
                    if (owner_q) d_rdata_d  = '0;
                    else         if_rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            abort_q    <= 1'b0;
            err_src_q  <= 1'b0;
            dcnt_q     <= 8'd0;
            wcnt_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            abort_q    <= abort_d;
            err_src_q  <= err_src_d;
            dcnt_q     <= dcnt_d;
            wcnt_q     <= wcnt_d;
        end
    end

    // Every output decodes straight from flops; reset clears them without a clock.
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_ack    = (state_q == RESP) && !owner_q;
    assign d_ack     = (state_q == RESP) && owner_q;
    assign bus_err   = (state_q == RESP) && abort_q;
    assign err_src   = err_src_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer for the pipelined CPU, sharing one unified instruction/data memory between the IF-stage fetch port and the MEM-stage load/store port. It serialises requests, presents one transaction at a time to the memory through a req/ack handshake and returns one-cycle acknowledges that the pipeline uses as stall release. It also runs a watchdog that aborts hung transactions.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max BUSY cycles without mem_ack before abort (1..255, 8-bit counter)
- DFAIR, 2, max consecutive data grants while if_req is pending
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, valid in if_ack cycle
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  load data, valid in d_ack cycle
- d_ack  out  1  one-cycle data completion pulse
- mem_req, mem_we  out  1  memory request / write
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8
- mem_rdata  in  DATA_W; mem_ack  in  1  memory completion, one cycle
- bus_err  out  1  one-cycle pulse with the ack of an aborted transaction
- err_src  out  1  0 = fetch aborted, 1 = data aborted; updated with bus_err

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: no request -> stay. Requests sampled; grant -> latch owner, address, we, wdata, be into registers; go BUSY.
- Grant rule: only d_req -> data; only if_req -> fetch; both -> data, unless dcnt == DFAIR, then fetch.
- dcnt: +1 (saturating) on data grant while if_req high; cleared on any fetch grant or data grant with if_req low.
- BUSY: mem_req = 1, mem_* driven from latched registers, stable for whole transaction; mem_we = 0 for fetch. Watchdog wcnt +1 each BUSY cycle.
- BUSY & mem_ack -> capture mem_rdata into owner's rdata register (load/fetch only; store leaves d_rdata unchanged); go RESP.
- BUSY & !mem_ack & wcnt == TIMEOUT-1 -> abort: owner rdata = 0, bus_err flag, err_src = owner; go RESP.
- RESP: owner's ack = 1 for exactly this cycle; bus_err = 1 if aborted; no request sampling (requester updates req this cycle); go IDLE.
- mem_ack in IDLE or RESP ignored.
- Non-owner port sees no ack; its request waits.

## Timing
- Reset (async, immediate): state IDLE, mem_req/mem_we 0, mem_addr/mem_wdata/mem_be 0, if_ack/d_ack/bus_err 0, err_src 0, if_rdata/d_rdata 0, dcnt/wcnt 0.
- Reset mid-transaction: mem_req drops asynchronously; no ack issued; memory side discards the transaction.
- Request in IDLE at cycle N -> mem_req high from N+1; mem_ack at cycle M -> ack + rdata at M+1; next grant sampled at M+2, mem_req at M+3.
- Minimum transaction (mem_ack in first BUSY cycle): req at N, ack at N+2, 3 cycles per access.
- Abort: mem_req high cycles N+1..N+TIMEOUT, ack + bus_err at N+TIMEOUT+1.
- mem_ack coinciding with timeout cycle: ack wins, no bus_err.
- Simultaneous if_req and d_req in IDLE: fairness rule above, decided in one cycle.
- Outputs all registered; no combinational path from inputs to outputs.

## Test plan
- Fetch only: if_req, if_addr=0x100, memory acks after 2 cycles with 0x8C010004 -> mem_addr=0x100, mem_we=0 for 2 cycles, if_ack one cycle with if_rdata=0x8C010004, d_ack never.
- Store then load: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF, then load 0x40 -> mem_we=1 with those values, d_ack; d_rdata unchanged; load returns 0xDEADBEEF.
- Contention/fairness: if_req and d_req held continuously, DFAIR=2 -> grant order D,D,I,D,D,I; every transaction completes with exactly one ack.
- Timeout: TIMEOUT=4, mem_ack never -> mem_req high 4 cycles, then d_ack + bus_err + err_src=1, d_rdata=0, state returns IDLE; mem_ack arriving afterwards ignored.
- Ack on timeout edge: mem_ack in 4th BUSY cycle with TIMEOUT=4 -> normal ack, bus_err=0, rdata captured.
- Async reset in BUSY: rst_n low between edges -> mem_req 0 immediately, no ack, all outputs at reset values; after release new fetch completes normally.
